// File: rtl/pipe_pkg.sv
// Shared constants and packed payload layout for the MEM->WB stage register.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  // Payload layout, MSB first: {wb_en, mem_r_en, alu_result, mem_result, dest}
  localparam int WB_EN_W    = 1;
  localparam int MEM_R_EN_W = 1;
  localparam int FLAGS_W    = WB_EN_W + MEM_R_EN_W;
  localparam int PAY_W_DEF  = FLAGS_W + 2 * DATA_W_DEF + DEST_W_DEF;

  function automatic int pay_w(input int data_w, input int dest_w);
    return FLAGS_W + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance only while below the saturation value
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid entry,
// SRAM freeze, flush and a saturating stall-cycle counter.
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_result,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_result,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int PAY_W = pay_w(DATA_W, DEST_W);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [1:0]       occ_q;
  logic             acc;
  logic             emit;
  logic             stall_inc;

  assign in_pay = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_result, in_dest};

  // With a skid entry, ready depends only on registered state; without it,
  // ready passes through from WB so a full stage can still stream.
  assign in_ready  = ((SKID != 0) ? ~skid_v_q : (~main_v_q | out_ready)) & ~freeze & ~rst;
  assign out_valid = main_v_q & ~freeze;
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Next-state selection in priority order; payload regs load only on a transfer
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (emit && skid_v_q) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (emit && acc) begin
      main_d   = in_pay;
    end else if (emit) begin
      main_v_d = 1'b0;
    end else if (acc && !main_v_q) begin
      main_d   = in_pay;
      main_v_d = 1'b1;
    end else if (acc && (SKID != 0)) begin
      skid_d   = in_pay;
      skid_v_d = 1'b1;
    end
  end

  // State registers, synchronous reset clears flags and payload
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      occ_q    <= {1'b0, main_v_d} + {1'b0, skid_v_d};
    end
  end

  assign occupancy      = occ_q;
  assign out_wb_en      = main_q[PAY_W-1];
  assign out_mem_r_en   = main_q[PAY_W-2];
  assign out_alu_result = main_q[DEST_W+DATA_W +: DATA_W];
  assign out_mem_result = main_q[DEST_W +: DATA_W];
  assign out_dest       = main_q[DEST_W-1:0];

  // A held entry that cannot leave this cycle counts as a stall
  assign stall_inc = main_v_q & (~out_ready | freeze);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cycles)
  );

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench: accepted entries are queued, a negedge monitor checks the
// DUT against the queue. A second instance (SKID=0, CNT_W=4) covers saturation
// and the pass-through ready path.
module tb_mem_wb_pipe_reg;

  localparam int PW = 70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults: SKID=1, CNT_W=16)
  logic        rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  logic        in_wb_en, in_mem_r_en, out_wb_en, out_mem_r_en;
  logic [31:0] in_alu, in_mem, out_alu, out_mem;
  logic [3:0]  in_dest, out_dest;
  logic [1:0]  occupancy;
  logic [15:0] stall;

  // Second instance
  logic        s0_freeze, s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic        s0_in_wb_en, s0_in_mem_r_en, s0_out_wb_en, s0_out_mem_r_en;
  logic [31:0] s0_in_alu, s0_in_mem, s0_out_alu, s0_out_mem;
  logic [3:0]  s0_in_dest, s0_out_dest;
  logic [1:0]  s0_occupancy;
  logic [3:0]  s0_stall;

  mem_wb_pipe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
    .in_alu_result(in_alu), .in_mem_result(in_mem), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_alu_result(out_alu), .out_mem_result(out_mem), .out_dest(out_dest),
    .occupancy(occupancy), .stall_cycles(stall)
  );

  mem_wb_pipe_reg #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .freeze(s0_freeze), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_wb_en(s0_in_wb_en), .in_mem_r_en(s0_in_mem_r_en),
    .in_alu_result(s0_in_alu), .in_mem_result(s0_in_mem), .in_dest(s0_in_dest),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_wb_en(s0_out_wb_en), .out_mem_r_en(s0_out_mem_r_en),
    .out_alu_result(s0_out_alu), .out_mem_result(s0_out_mem), .out_dest(s0_out_dest),
    .occupancy(s0_occupancy), .stall_cycles(s0_stall)
  );

  logic [PW-1:0] in_pay, out_pay, s0_in_pay, s0_out_pay;
  assign in_pay     = {in_wb_en, in_mem_r_en, in_alu, in_mem, in_dest};
  assign out_pay    = {out_wb_en, out_mem_r_en, out_alu, out_mem, out_dest};
  assign s0_in_pay  = {s0_in_wb_en, s0_in_mem_r_en, s0_in_alu, s0_in_mem, s0_in_dest};
  assign s0_out_pay = {s0_out_wb_en, s0_out_mem_r_en, s0_out_alu, s0_out_mem, s0_out_dest};

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: entries held by the stage, in acceptance order
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] shown_exp = '0;
  int            stall_exp = 0;
  int            sz;

  // Monitor: compare everything the DUT presents, then retire an emitted entry
  always @(negedge clk) begin
    sz = exp_q.size();
    if (sz > 0) shown_exp = exp_q[0];
    check("out_valid", PW'(out_valid), PW'((sz > 0) && !freeze));
    check("in_ready",  PW'(in_ready),  PW'((sz < 2) && !freeze && !rst));
    check("occupancy", PW'(occupancy), PW'(sz));
    check("payload",   out_pay,        shown_exp);
    check("stall",     PW'(stall),     PW'(stall_exp));
    if (rst) stall_exp = 0;
    else if ((sz > 0) && (!out_ready || freeze) && (stall_exp < 65535)) stall_exp++;
    if ((sz > 0) && !freeze && out_ready) void'(exp_q.pop_front());
  end

  // Acceptance tracker: pushes what the stage takes in at the coming edge
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      shown_exp = '0;
    end else if (flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(in_pay);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pay();
    in_wb_en    = 1'($urandom);
    in_mem_r_en = 1'($urandom);
    in_alu      = $urandom;
    in_mem      = $urandom;
    in_dest     = 4'($urandom);
  endtask

  task automatic send(input logic [31:0] alu);
    rand_pay();
    in_alu   = alu;
    in_valid = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_pay();
    s0_freeze = 1'b0; s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_in_wb_en = 1'b1; s0_in_mem_r_en = 1'b0; s0_in_alu = 32'hCAFE_0001;
    s0_in_mem = 32'h1234_5678; s0_in_dest = 4'hA;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Back-to-back streaming
    out_ready = 1'b1;
    send(32'h11); send(32'h22); send(32'h33);
    in_valid = 1'b0;
    repeat (3) cyc();

    // Skid fill, extra offer while full, then drain
    out_ready = 1'b0;
    send(32'hA1); send(32'hA2); send(32'hA3);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    // Freeze with a held entry
    out_ready = 1'b0;
    send(32'hF0);
    in_valid = 1'b0;
    freeze = 1'b1;
    out_ready = 1'b1;
    repeat (5) cyc();
    freeze = 1'b0;
    repeat (2) cyc();

    // Flush while full with a simultaneous offer
    out_ready = 1'b0;
    send(32'hB1); send(32'hB2);
    rand_pay();
    in_alu = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();

    // Reset mid-stream while full
    out_ready = 1'b0;
    send(32'hC1); send(32'hC2);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      rand_pay();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    // Second instance: saturation and pass-through ready
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    @(negedge clk);
    check("s0_in_ready_empty", PW'(s0_in_ready), PW'(1));
    cyc();
    s0_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      @(negedge clk);
      check("s0_stall", PW'(s0_stall), PW'((i < 15) ? i : 15));
    end
    check("s0_occupancy", PW'(s0_occupancy), PW'(1));
    check("s0_out_valid", PW'(s0_out_valid), PW'(1));
    check("s0_payload",   s0_out_pay, {1'b1, 1'b0, 32'hCAFE_0001, 32'h1234_5678, 4'hA});
    check("s0_in_ready_blocked", PW'(s0_in_ready), PW'(0));
    s0_out_ready = 1'b1;
    #1;
    check("s0_in_ready_follow1", PW'(s0_in_ready), PW'(1));
    s0_out_ready = 1'b0;
    #1;
    check("s0_in_ready_follow0", PW'(s0_in_ready), PW'(0));
    s0_out_ready = 1'b1;
    s0_freeze    = 1'b1;
    #1;
    check("s0_in_ready_freeze", PW'(s0_in_ready), PW'(0));
    s0_freeze = 1'b0;
    cyc();
    @(negedge clk);
    check("s0_drained", PW'(s0_occupancy), PW'(0));
    check("s0_stall_held", PW'(s0_stall), PW'(15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
